// File: rtl/mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// mips_instr_encoder
//
// Purpose:
//   Encodes MIPS R / I / J / JR field sets into 32-bit instruction words and
//   queues each word in a small FIFO. Each word carries its byte address, which
//   starts at BASE_ADDR and advances by 4 per accepted field set, and a flag
//   that marks JR encodings.
//
// Parameters:
//   BASE_ADDR  byte address given to the first emitted word
//   DEPTH      FIFO entries (2, 4 or 8)
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready depends on registered state only
//   in_fmt              0=R, 1=I, 2=J, 3=JR
//   in_op, in_funct     opcode / function fields
//   in_rs, in_rt,
//   in_rd, in_shamt     register and shift fields
//   in_imm, in_target   I-type immediate, J-type target
//   out_valid/out_ready output handshake
//   out_instr, out_addr encoded word and its byte address (0 while empty)
//   out_is_jr           word was encoded from fmt=3
//   err                 one-cycle pulse after accepting a malformed field set
//
// Optional feature:
//   ENCODER_FIELD_CHECK_EN  when defined, builds the malformed-field checker that
//                           drives err; otherwise err is tied to 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mips_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_fmt,
    input  logic [5:0]  in_op,
    input  logic [5:0]  in_funct,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_is_jr,
    output logic        err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] FMT_R  = 2'd0;
    localparam logic [1:0] FMT_I  = 2'd1;
    localparam logic [1:0] FMT_J  = 2'd2;
    localparam logic [1:0] FMT_JR = 2'd3;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // Pointer wrap relies on DEPTH being a power of two.
    generate
        if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
            $error("mips_instr_encoder: DEPTH must be 2, 4 or 8");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Combinational encoder
    // -------------------------------------------------------------------------
    logic [31:0] enc_word;
    logic        enc_is_jr;

    always_comb begin
        enc_word  = 32'h0;
        enc_is_jr = 1'b0;
        case (in_fmt)
            FMT_R:   enc_word = {6'b0, in_rs, in_rt, in_rd, in_shamt, in_funct};
            FMT_I:   enc_word = {in_op, in_rs, in_rt, in_imm};
            FMT_J:   enc_word = {in_op, in_target};
            FMT_JR: begin
                enc_word  = {6'b0, in_rs, 15'b0, FUNCT_JR};
                enc_is_jr = 1'b1;
            end
            default: enc_word = 32'h0;
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO control
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [31:0]      addr_q, addr_d;

    logic [31:0] instr_mem_q [DEPTH];
    logic [31:0] addr_mem_q  [DEPTH];
    logic        jr_mem_q    [DEPTH];

    logic push;
    logic pop;

    // in_ready comes from a flop, so a full FIFO refuses a push even when the
    // same cycle pops; the freed slot is only advertised on the next cycle.
    assign in_ready  = ready_q;
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid & ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            addr_d   = addr_q + 32'd4;      // wraps naturally past 32'hFFFFFFFC
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        ready_d = (cnt_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            addr_q   <= BASE_ADDR;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            addr_q   <= addr_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            instr_mem_q[wr_ptr_q] <= enc_word;
            addr_mem_q[wr_ptr_q]  <= addr_q;
            jr_mem_q[wr_ptr_q]    <= enc_is_jr;
        end
    end

    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign out_addr  = out_valid ? addr_mem_q[rd_ptr_q]  : 32'h0;
    assign out_is_jr = out_valid ? jr_mem_q[rd_ptr_q]    : 1'b0;

    // -------------------------------------------------------------------------
    // Optional malformed-field checker
    // -------------------------------------------------------------------------
`ifdef ENCODER_FIELD_CHECK_EN
    logic malformed;
    logic err_q, err_d;

    always_comb begin
        malformed = 1'b0;
        case (in_fmt)
            FMT_R:   malformed = (in_op != 6'd0);
            FMT_JR:  malformed = (in_rt != 5'd0) || (in_rd != 5'd0) || (in_shamt != 5'd0);
            default: malformed = (in_op == 6'd0);   // I and J need a nonzero opcode
        endcase
        err_d = push & malformed;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/mips_instr_encoder.md
MIPS_INSTR_ENCODER -- requirements
Module: mips_instr_encoder

Interface
REQ-001 Parameter: BASE_ADDR, 32'h00000000, byte address given to the first emitted word.
REQ-002 Parameter: DEPTH, 4, output FIFO entries; legal values 2, 4 or 8.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  field set on in_* is valid.
REQ-006 Port: in_ready  output  1  encoder accepts a field set this cycle.
REQ-007 Port: in_fmt  input  2  0=R, 1=I, 2=J, 3=JR.
REQ-008 Port: in_op / in_funct  input  6 each  opcode / function fields.
REQ-009 Port: in_rs / in_rt / in_rd / in_shamt  input  5 each  register and shift fields.
REQ-010 Port: in_imm  input  16  I-type immediate; in_target input 26, J-type target.
REQ-011 Port: out_valid  output  1  out_* holds an encoded word.
REQ-012 Port: out_ready  input  1  consumer takes the word this cycle.
REQ-013 Port: out_instr  output  32  encoded instruction word.
REQ-014 Port: out_addr  output  32  byte address of out_instr.
REQ-015 Port: out_is_jr  output  1  out_instr was encoded from fmt=3.
REQ-016 Port: err  output  1  one-cycle pulse on accepting a malformed field set.

Function
REQ-017 Accept (push) occurs when in_valid and in_ready are both 1; pop occurs when out_valid and out_ready are both 1.
REQ-018 Encoding: R = {6'b0,rs,rt,rd,shamt,funct}; I = {op,rs,rt,imm}; J = {op,target}; JR = {6'b0,rs,15'b0,6'b001000}.
REQ-019 For R and JR, in_op is ignored; for JR, in_rt, in_rd, in_shamt and in_funct are ignored.
REQ-020 Encoding is combinational on the inputs; the encoded word, its address and the JR flag are written into the FIFO on push.
REQ-021 Latency: with the FIFO empty, out_valid rises on the cycle after push, carrying that word.
REQ-022 Ordering is strictly FIFO; out_* stay stable while out_valid=1 and out_ready=0.
REQ-023 in_ready = (occupancy < DEPTH); it is registered-state only and has no combinational path from out_ready.
REQ-024 When full, a push is refused even if a pop occurs in the same cycle; in_ready rises on the following cycle.
REQ-025 Simultaneous push and pop at non-full, non-empty occupancy leaves occupancy unchanged.
REQ-026 Address counter starts at BASE_ADDR and increments by 4 per push; 32'hFFFFFFFC wraps to 32'h00000000.
REQ-027 FIFO pointers wrap modulo DEPTH; occupancy ranges from 0 to DEPTH.

Reset
REQ-028 While reset=1 on a clock edge: occupancy=0, out_valid=0, in_ready=0, err=0, and the address counter loads BASE_ADDR.
REQ-029 Reset asserted mid-stream discards all buffered words, with no partial pop.
REQ-030 in_ready=1 from the first cycle after reset deasserts.
REQ-031 out_instr, out_addr and out_is_jr read 0 while out_valid=0.

Configuration
REQ-032 Macro ENCODER_FIELD_CHECK_EN, when defined, pulses err for one cycle, the cycle after a push whose fields are malformed:
- R with in_op!=0;
- JR with in_rt, in_rd or in_shamt nonzero;
- I or J with in_op==0.
REQ-033 With the macro defined, a malformed set is still encoded and pushed per REQ-018.
REQ-034 Without ENCODER_FIELD_CHECK_EN, err is tied to 0 and no check logic is built.

Verification
REQ-035 Push JR with rs=31, out_ready=1 -> next cycle out_instr=32'h03E00008, out_is_jr=1, out_addr=BASE_ADDR.
REQ-036 Push R (rs=1, rt=2, rd=3, shamt=0, funct=6'h20), then I (op=8, rs=1, rt=2, imm=5), then J (op=2, target=26'h10) -> out_instr 32'h00221820, 32'h20220005, 32'h08000010; addresses BASE, BASE+4, BASE+8.
REQ-037 out_ready=0 and push every cycle, DEPTH=4 -> four pushes accepted, then in_ready=0; raise out_ready with in_valid held -> pop/refused-push cycle, then in_ready=1 the next cycle; all words arrive in order.
REQ-038 BASE_ADDR=32'hFFFFFFF8, push 3 words -> out_addr FFFFFFF8, FFFFFFFC, 00000000.
REQ-039 Buffer 3 words, assert reset for 1 cycle -> out_valid=0; the next push emits with out_addr=BASE_ADDR.
REQ-040 With ENCODER_FIELD_CHECK_EN, push JR with rt=5 -> err=1 for one cycle and out_instr=32'h03E00008 (rs=31); without the macro -> err stays 0.
